// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared states, opcodes, headings and response codes for the tour sequencer
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } tour_state_e;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [7:0] HDG_W = 8'h3F;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

endpackage

// File: rtl/tour_move_decode.sv
// rtl/tour_move_decode.sv - maps a one-hot knight move to vertical/horizontal heading and square count
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] v_heading,
  output logic [3:0] v_squares,
  output logic [7:0] h_heading,
  output logic [3:0] h_squares
);

  logic [2:0] bit_sel;

  // Lowest set bit wins; an all-zero move falls through to bit0.
  always_comb begin
    bit_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (move[i]) bit_sel = 3'(i);
    end
  end

  always_comb begin
    v_heading = HDG_N;
    v_squares = 4'd2;
    h_heading = HDG_E;
    h_squares = 4'd1;
    case (bit_sel)
      3'd0: begin v_heading = HDG_N; v_squares = 4'd2; h_heading = HDG_E; h_squares = 4'd1; end
      3'd1: begin v_heading = HDG_N; v_squares = 4'd2; h_heading = HDG_W; h_squares = 4'd1; end
      3'd2: begin v_heading = HDG_N; v_squares = 4'd1; h_heading = HDG_W; h_squares = 4'd2; end
      3'd3: begin v_heading = HDG_S; v_squares = 4'd1; h_heading = HDG_W; h_squares = 4'd2; end
      3'd4: begin v_heading = HDG_S; v_squares = 4'd2; h_heading = HDG_W; h_squares = 4'd1; end
      3'd5: begin v_heading = HDG_S; v_squares = 4'd2; h_heading = HDG_E; h_squares = 4'd1; end
      3'd6: begin v_heading = HDG_S; v_squares = 4'd1; h_heading = HDG_E; h_squares = 4'd2; end
      3'd7: begin v_heading = HDG_N; v_squares = 4'd1; h_heading = HDG_E; h_squares = 4'd2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_move_sequencer.sv
// rtl/tour_move_sequencer.sv - steps a knight's tour as vertical then horizontal commands, muxed with the UART path
// Optional illegal-move check enabled by defining TOUR_ILLEGAL_CHK_EN.
module tour_move_sequencer
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_err
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  v_heading, h_heading;
  logic [3:0]  v_squares, h_squares;
  logic [15:0] v_cmd, h_cmd;

  move_decode u_move_decode (
    .move      (move),
    .v_heading (v_heading),
    .v_squares (v_squares),
    .h_heading (h_heading),
    .h_squares (h_squares)
  );

  assign v_cmd = {OP_MOVE, v_heading, v_squares};
  assign h_cmd = {OP_FANFARE, h_heading, h_squares};

`ifdef TOUR_ILLEGAL_CHK_EN
  logic err_q, err_d;
  logic move_bad;
  assign move_bad = (move == 8'h00) || ((move & (move - 8'd1)) != 8'h00);
  assign tour_err = err_q;
`else
  assign tour_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
`ifdef TOUR_ILLEGAL_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef TOUR_ILLEGAL_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef TOUR_ILLEGAL_CHK_EN
    err_d   = err_q;
`endif
    cmd     = cmd_UART;
    cmd_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        if (start_tour) begin
          idx_d   = 5'd0;
          state_d = VERT;
`ifdef TOUR_ILLEGAL_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end
      VERT: begin
        cmd     = v_cmd;
        cmd_rdy = 1'b1;
`ifdef TOUR_ILLEGAL_CHK_EN
        if (move_bad) begin
          cmd_rdy = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (clr_cmd_rdy) begin
          state_d = WAIT_V;
        end
`else
        if (clr_cmd_rdy) state_d = WAIT_V;
`endif
      end
      WAIT_V: begin
        cmd = v_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = h_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = h_cmd;
        if (send_resp) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mv_indx = idx_q;
  assign resp    = ((state_q == IDLE) || (idx_q == LAST_IDX)) ? RESP_ACK : RESP_POS;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// tb/tb_tour_move_sequencer.sv - directed self-checking bench for tour_move_sequencer
module tb_tour_move_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic        tour_err;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_count = 0;
  bit count_en = 0;
  logic rdy_prev = 1'b0;

  logic [15:0] v_exp [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                             16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
  logic [15:0] h_exp [8] = '{16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2,
                             16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

  tour_move_sequencer #(.NUM_MOVES(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp),
    .tour_err     (tour_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_en) begin
      if (cmd_rdy && !rdy_prev) rdy_count++;
      rdy_prev = cmd_rdy;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; start_tour = 1'b0; move = 8'h02;
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    #3;
    check("rst_mv_indx", 16'(mv_indx), 16'd0);
    check("rst_resp", 16'(resp), 16'h00A5);
    check("rst_tour_err", 16'(tour_err), 16'd0);
    check("rst_cmd_pass", cmd, 16'h2003);
    check("rst_rdy_pass", 16'(cmd_rdy), 16'd1);
    tick(); rst = 1'b0; tick();
    check("idle_cmd_pass", cmd, 16'h2003);

    // First move (-1,+2), with UART ready held high to prove it is blocked
    move = 8'h02;
    pulse_start();
    check("m0_vert_cmd", cmd, 16'h2002);
    check("m0_vert_rdy", 16'(cmd_rdy), 16'd1);
    check("m0_resp", 16'(resp), 16'h005A);
    check("m0_idx", 16'(mv_indx), 16'd0);
    pulse_send();
    check("vert_ignores_send", 16'(cmd_rdy), 16'd1);
    check("vert_cmd_stable", cmd, 16'h2002);
    pulse_clr();
    check("waitv_rdy_low", 16'(cmd_rdy), 16'd0);
    pulse_clr();
    check("waitv_ignores_clr", 16'(cmd_rdy), 16'd0);
    pulse_send();
    check("m0_horz_cmd", cmd, 16'h33F1);
    check("m0_horz_rdy", 16'(cmd_rdy), 16'd1);
    pulse_start();
    check("start_ignored_idx", 16'(mv_indx), 16'd0);
    check("start_ignored_cmd", cmd, 16'h33F1);
    pulse_clr();
    check("waith_rdy_low", 16'(cmd_rdy), 16'd0);
    move = 8'h08;
    pulse_send();
    check("m1_idx", 16'(mv_indx), 16'd1);
    check("m1_vert_cmd", cmd, 16'h27F1);
    pulse_clr();
    pulse_send();
    check("m1_horz_cmd", cmd, 16'h33F2);

    // Full 24-move tour
    do_reset();
    cmd_rdy_UART = 1'b0;
    #1;
    rdy_prev = 1'b0; rdy_count = 0; count_en = 1;
    move = 8'h01;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      move = 8'h01 << (i % 8);
      #1;
      check($sformatf("tour%0d_idx", i), 16'(mv_indx), 16'(i));
      check($sformatf("tour%0d_vcmd", i), cmd, v_exp[i % 8]);
      check($sformatf("tour%0d_resp", i), 16'(resp), (i == 23) ? 16'h00A5 : 16'h005A);
      pulse_clr();
      pulse_send();
      check($sformatf("tour%0d_hcmd", i), cmd, h_exp[i % 8]);
      pulse_clr();
      pulse_send();
    end
    tick();
    count_en = 0;
    check("tour_rdy_count", 16'(rdy_count), 16'd48);
    check("tour_end_resp", 16'(resp), 16'h00A5);
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h1234; #1;
    check("tour_end_rdy_pass", 16'(cmd_rdy), 16'd1);
    check("tour_end_cmd_pass", cmd, 16'h1234);

    // Reset in WAIT_H at mv_indx 7
    do_reset();
    move = 8'h80;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
    end
    pulse_clr(); pulse_send(); pulse_clr();
    check("pre_rst_idx", 16'(mv_indx), 16'd7);
    check("pre_rst_rdy", 16'(cmd_rdy), 16'd0);
    rst = 1'b1; #1;
    check("mid_rst_rdy", 16'(cmd_rdy), 16'd1);
    check("mid_rst_idx", 16'(mv_indx), 16'd0);
    check("mid_rst_resp", 16'(resp), 16'h00A5);
    tick(); rst = 1'b0; cmd_rdy_UART = 1'b0; tick(); tick();
    check("post_rst_no_replay", 16'(cmd_rdy), 16'd0);

    // Two-bit move
    move = 8'h03; cmd_rdy_UART = 1'b1;
    pulse_start();
`ifdef TOUR_ILLEGAL_CHK_EN
    check("illegal_no_rdy", 16'(cmd_rdy), 16'd0);
    tick();
    check("illegal_err", 16'(tour_err), 16'd1);
    check("illegal_idle_pass", 16'(cmd_rdy), 16'd1);
`else
    check("multi_bit_cmd", cmd, 16'h2002);
    check("multi_bit_rdy", 16'(cmd_rdy), 16'd1);
    check("multi_bit_err", 16'(tour_err), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tour_move_sequencer.md
TOUR_MOVE_SEQUENCER -- requirements
Module: tour_move_sequencer

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, meaning the number of moves in one tour.
REQ-002 SHALL have ports clk in 1 (system clock) and rst in 1 (reset, asynchronous, active-high).
REQ-003 SHALL have ports start_tour in 1, a single-cycle pulse that begins a tour.
REQ-004 SHALL have ports move in 8 (one-hot move for the current mv_indx) and mv_indx out 5 (current move index).
REQ-005 SHALL have ports cmd_UART in 16 and cmd_rdy_UART in 1, carrying the remote command path.
REQ-006 SHALL have ports clr_cmd_rdy in 1 and send_resp in 1, both from the command processor.
REQ-007 SHALL have ports cmd out 16, cmd_rdy out 1, resp out 8 and tour_err out 1.

Function
REQ-008 SHALL implement states IDLE, VERT, WAIT_V, HORZ and WAIT_H.
REQ-009 SHALL, in IDLE, drive cmd=cmd_UART and cmd_rdy=cmd_rdy_UART as a pass-through.
REQ-010 SHALL, on start_tour in IDLE, clear mv_indx to 0 and enter VERT on the next clock.
REQ-011 SHALL ignore start_tour outside IDLE, and SHALL block the UART path outside IDLE.
REQ-012 SHALL use the move map bit0(+1,+2), bit1(-1,+2), bit2(-2,+1), bit3(-2,-1), bit4(-1,-2), bit5(+1,-2), bit6(+2,-1), bit7(+2,+1), given as (dx,dy).
REQ-013 SHALL, in VERT, drive cmd={4'b0010, heading, |dy|} with cmd_rdy=1, where the heading is north 8'h00 for dy>0 and south 8'h7F for dy<0.
REQ-014 SHALL, in HORZ, drive cmd={4'b0011, heading, |dx|} with cmd_rdy=1, where the heading is east 8'hBF for dx>0 and west 8'h3F for dx<0; opcode 0011 is move-with-fanfare.
REQ-015 SHALL hold cmd_rdy high in VERT and HORZ until clr_cmd_rdy, then move to WAIT_V or WAIT_H respectively on the next clock.
REQ-016 SHALL, in WAIT_V, enter HORZ on send_resp.
REQ-017 SHALL, in WAIT_H, on send_resp, return to IDLE if mv_indx==NUM_MOVES-1, otherwise increment mv_indx and enter VERT.
REQ-018 SHALL hold cmd stable while cmd_rdy=1 during a tour.
REQ-019 SHALL ignore send_resp in VERT and HORZ, and SHALL ignore clr_cmd_rdy in WAIT_V and WAIT_H.
REQ-020 SHALL drive resp=8'hA5 in IDLE or when mv_indx==NUM_MOVES-1, and resp=8'h5A otherwise.
REQ-021 SHALL keep mv_indx 5 bits wide and SHALL never let it exceed NUM_MOVES-1.
REQ-022 SHALL register the state and mv_indx; cmd and resp MAY be combinational from them.

Reset
REQ-023 SHALL, on rst, immediately force state=IDLE, mv_indx=0 and tour_err=0, giving cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and resp=8'hA5.
REQ-024 SHALL, when rst is asserted mid-tour in any state, abandon the tour; no command is replayed after rst deasserts.

Configuration
REQ-025 SHALL, with TOUR_ILLEGAL_CHK_EN defined, enter IDLE from VERT when move is not one-hot (zero or multiple bits), and set tour_err until the next accepted start_tour.
REQ-026 SHALL, without TOUR_ILLEGAL_CHK_EN, decode move by lowest set bit, treat 8'h00 as bit0, and tie tour_err to 0.

Structure
REQ-027 SHALL place the state enum, opcode constants, heading constants (N/S/E/W) and resp constants (ACK 8'hA5, POS 8'h5A) in the shared package tour_pkg.
REQ-028 SHALL contain one combinational sub-module, move_decode, that maps move to vertical and horizontal heading plus square count.

Verification
REQ-029 SHALL cover pass-through after reset: cmd_UART=16'h2003 with cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1, resp=8'hA5.
REQ-030 SHALL cover a first move: start_tour with move=8'h02 -> cmd=16'h2002; after clr_cmd_rdy and send_resp -> cmd=16'h33F1; resp=8'h5A.
REQ-031 SHALL cover a south-west move: move=8'h08 -> vertical cmd 16'h27F1, then horizontal cmd 16'h33F2.
REQ-032 SHALL cover a full tour: 24 moves -> 48 cmd_rdy assertions and mv_indx counting 0..23; after the final send_resp -> IDLE, resp=8'hA5, UART path restored.
REQ-033 SHALL cover reset mid-tour: rst asserted in WAIT_H at mv_indx=7 -> cmd_rdy=cmd_rdy_UART, mv_indx=0, resp=8'hA5.
REQ-034 SHALL cover the illegal-move check with TOUR_ILLEGAL_CHK_EN: move=8'h03 -> tour_err=1, IDLE, no cmd_rdy pulse; without the macro -> cmd=16'h2002 (bit0 decode).
